// File: rtl/pd8_pkg.sv
// Shared constants, FSM state type and code-to-one-hot helper for the PD8
// receive-side decoder.
package pd8_pkg;

   localparam int CODE_W = 3;
   localparam int N_OUT  = 1 << CODE_W;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      HOLD   = 2'd2
   } pd8_state_e;

   // One-hot image of an encoded channel index.
   function automatic logic [N_OUT-1:0] pd8_decode(input logic [CODE_W-1:0] code);
      logic [N_OUT-1:0] one_hot;
      one_hot = '0;
      one_hot[code] = 1'b1;
      return one_hot;
   endfunction

endpackage

// File: rtl/pd8_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pd8_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear first, otherwise step up until all ones and stick there.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pd8_decoder.sv
// Registered 3-to-8 decoder at the receive end of the PE8 link. Regenerates
// the one-hot request, stretches it for HOLD_CYCLES after valid drops, and
// keeps a sticky seen-channel mask plus a saturating code-change counter.
module pd8_decoder
   import pd8_pkg::*;
#(
   parameter int N_OUT       = 8,
   parameter int CODE_W      = 3,
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CODE_W-1:0] code_in,
   input  logic              valid_in,
   input  logic              clr,
   output logic [N_OUT-1:0]  dec_out,
   output logic              valid_out,
   output logic              changed,
   output logic [N_OUT-1:0]  seen_mask,
   output logic [CNT_W-1:0]  event_cnt
);

   // Hold counter needs to represent HOLD_CYCLES-1; keep at least one bit.
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_INIT =
      HOLD_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);

   pd8_state_e        state_q, state_d;
   logic [N_OUT-1:0]  dec_q, dec_d;
   logic              vld_q, vld_d;
   logic              chg_q, chg_d;
   logic [N_OUT-1:0]  seen_q, seen_d;
   logic [CODE_W-1:0] last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [N_OUT-1:0]  code_oh;

   assign code_oh = pd8_decode(code_in);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: any valid input lands in ACTIVE; the hold window
   // drains back to IDLE once the counter has reached zero.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (valid_in) state_d = ACTIVE;
         end
         ACTIVE: begin
            if (!valid_in) state_d = (HOLD_CYCLES > 0) ? HOLD : IDLE;
         end
         HOLD: begin
            if (valid_in)            state_d = ACTIVE;
            else if (hold_q == '0)   state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values: decode, stretch, change detect, seen mask.
   always_comb begin
      dec_d  = dec_q;
      vld_d  = vld_q;
      chg_d  = 1'b0;
      last_d = last_q;
      hold_d = hold_q;
      if (valid_in) begin
         dec_d  = code_oh;
         vld_d  = 1'b1;
         last_d = code_in;
         // Entry from IDLE always counts as a change, even for a repeated code.
         chg_d  = (state_q == IDLE) || (code_in != last_q);
      end else begin
         case (state_q)
            ACTIVE: begin
               if (HOLD_CYCLES > 0) begin
                  hold_d = HOLD_INIT;
               end else begin
                  dec_d = '0;
                  vld_d = 1'b0;
               end
            end
            HOLD: begin
               if (hold_q == '0) begin
                  dec_d = '0;
                  vld_d = 1'b0;
               end else begin
                  hold_d = hold_q - HOLD_W'(1);
               end
            end
            default: begin
               dec_d = '0;
               vld_d = 1'b0;
            end
         endcase
      end
      // clr drops this cycle's contribution to the mask.
      if (clr) begin
         seen_d = '0;
      end else if (valid_in) begin
         seen_d = seen_q | code_oh;
      end else begin
         seen_d = seen_q;
      end
   end

   // Output and bookkeeping registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         dec_q  <= '0;
         vld_q  <= 1'b0;
         chg_q  <= 1'b0;
         seen_q <= '0;
         last_q <= '0;
         hold_q <= '0;
      end else begin
         dec_q  <= dec_d;
         vld_q  <= vld_d;
         chg_q  <= chg_d;
         seen_q <= seen_d;
         last_q <= last_d;
         hold_q <= hold_d;
      end
   end

   pd8_sat_counter #(
      .CNT_W (CNT_W)
   ) u_event_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .inc_i (chg_d),
      .cnt_o (event_cnt)
   );

   assign dec_out   = dec_q;
   assign valid_out = vld_q;
   assign changed   = chg_q;
   assign seen_mask = seen_q;

endmodule

// File: tb/tb_pd8_decoder.sv
// Scoreboard bench for pd8_decoder: a behavioural model predicts the state
// after each edge, the prediction is queued when inputs are driven and
// popped against the DUT outputs just after the edge. A second instance
// with a 2-bit event counter shares the stimulus.
module tb_pd8_decoder;

   localparam int HOLD = 4;

   logic       clk;
   logic       rst;
   logic [2:0] code_in;
   logic       valid_in;
   logic       clr;

   logic [7:0] dec_out,   dec_out2;
   logic       valid_out, valid_out2;
   logic       changed,   changed2;
   logic [7:0] seen_mask, seen_mask2;
   logic [7:0] event_cnt;
   logic [1:0] event_cnt2;

   pd8_decoder #(.N_OUT(8), .CODE_W(3), .HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .code_in(code_in), .valid_in(valid_in), .clr(clr),
      .dec_out(dec_out), .valid_out(valid_out), .changed(changed),
      .seen_mask(seen_mask), .event_cnt(event_cnt)
   );

   pd8_decoder #(.N_OUT(8), .CODE_W(3), .HOLD_CYCLES(HOLD), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .code_in(code_in), .valid_in(valid_in), .clr(clr),
      .dec_out(dec_out2), .valid_out(valid_out2), .changed(changed2),
      .seen_mask(seen_mask2), .event_cnt(event_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] dec;
      logic       vld;
      logic       chg;
      logic [7:0] seen;
      logic [7:0] cnt;
      logic [1:0] cnt2;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Model state
   logic [7:0] m_dec;
   logic       m_vld;
   logic [2:0] m_last;
   logic [7:0] m_seen;
   int         m_cnt;
   int         m_cnt2;
   int         m_lows;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // Predict the registered outputs after the coming edge.
   task automatic model(input logic r, input logic v, input logic [2:0] c, input logic k,
                        output exp_t e);
      logic chg;
      chg = 1'b0;
      if (r) begin
         m_dec = '0; m_vld = 1'b0; m_last = '0; m_seen = '0;
         m_cnt = 0; m_cnt2 = 0; m_lows = 0;
      end else begin
         chg = v && (!m_vld || (c != m_last));
         if (v) begin
            m_dec  = 8'(1) << c;
            m_vld  = 1'b1;
            m_last = c;
            m_lows = 0;
         end else if (m_vld) begin
            m_lows++;
            if (m_lows > HOLD) begin
               m_vld = 1'b0;
               m_dec = '0;
            end
         end
         if (k) begin
            m_seen = '0; m_cnt = 0; m_cnt2 = 0;
         end else begin
            if (v) m_seen = m_seen | (8'(1) << c);
            if (chg) begin
               if (m_cnt  < 255) m_cnt++;
               if (m_cnt2 < 3)   m_cnt2++;
            end
         end
      end
      e.dec  = m_dec;
      e.vld  = m_vld;
      e.chg  = chg;
      e.seen = m_seen;
      e.cnt  = 8'(m_cnt);
      e.cnt2 = 2'(m_cnt2);
   endtask

   task automatic step(input logic r, input logic v, input logic [2:0] c, input logic k);
      exp_t e;
      rst = r; valid_in = v; code_in = c; clr = k;
      model(r, v, c, k, e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk_eq("sb_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk_eq("dec_out",    32'(dec_out),    32'(e.dec));
         chk_eq("valid_out",  32'(valid_out),  32'(e.vld));
         chk_eq("changed",    32'(changed),    32'(e.chg));
         chk_eq("seen_mask",  32'(seen_mask),  32'(e.seen));
         chk_eq("event_cnt",  32'(event_cnt),  32'(e.cnt));
         chk_eq("dec_out2",   32'(dec_out2),   32'(e.dec));
         chk_eq("valid_out2", 32'(valid_out2), 32'(e.vld));
         chk_eq("changed2",   32'(changed2),   32'(e.chg));
         chk_eq("seen_mask2", 32'(seen_mask2), 32'(e.seen));
         chk_eq("event_cnt2", 32'(event_cnt2), 32'(e.cnt2));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      rst = 1'b1; valid_in = 1'b0; code_in = '0; clr = 1'b0;

      // Reset state
      step(1, 0, 0, 0);
      step(1, 1, 3'd6, 1);
      chk_eq("rst_dec", 32'(dec_out), 32'h0);
      chk_eq("rst_cnt", 32'(event_cnt), 32'h0);

      // 1: single code 5, then the hold window
      step(0, 1, 3'd5, 0);
      chk_eq("t1_dec", 32'(dec_out), 32'h20);
      chk_eq("t1_chg", 32'(changed), 32'h1);
      chk_eq("t1_cnt", 32'(event_cnt), 32'h1);
      for (int i = 0; i < HOLD; i++) begin
         step(0, 0, 3'(i), 0);
         chk_eq("t1_hold_dec", 32'(dec_out), 32'h20);
         chk_eq("t1_hold_vld", 32'(valid_out), 32'h1);
      end
      step(0, 0, 3'd1, 0);
      chk_eq("t1_end_vld", 32'(valid_out), 32'h0);
      chk_eq("t1_end_dec", 32'(dec_out), 32'h0);

      // 2: stream 3,3,6,6,0
      step(1, 0, 0, 0);
      step(0, 1, 3'd3, 0);
      step(0, 1, 3'd3, 0);
      chk_eq("t2_rep_chg", 32'(changed), 32'h0);
      step(0, 1, 3'd6, 0);
      step(0, 1, 3'd6, 0);
      step(0, 1, 3'd0, 0);
      chk_eq("t2_cnt",  32'(event_cnt), 32'h3);
      chk_eq("t2_seen", 32'(seen_mask), 32'h49);

      // 3: re-entry from HOLD with the same code
      step(1, 0, 0, 0);
      step(0, 1, 3'd2, 0);
      step(0, 0, 3'd7, 0);
      step(0, 0, 3'd5, 0);
      step(0, 1, 3'd2, 0);
      chk_eq("t3_vld", 32'(valid_out), 32'h1);
      chk_eq("t3_chg", 32'(changed), 32'h0);
      chk_eq("t3_cnt", 32'(event_cnt), 32'h1);

      // 4: clr coincident with an accept
      step(1, 0, 0, 0);
      step(0, 1, 3'd1, 0);
      step(0, 1, 3'd4, 0);
      step(0, 1, 3'd7, 1);
      chk_eq("t4_seen", 32'(seen_mask), 32'h0);
      chk_eq("t4_cnt",  32'(event_cnt), 32'h0);
      chk_eq("t4_dec",  32'(dec_out), 32'h80);

      // 5: alternate 0,1 for six cycles; 2-bit counter saturates
      step(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 1, 3'(i % 2), 0);
      chk_eq("t5_cnt2", 32'(event_cnt2), 32'h3);
      chk_eq("t5_cnt",  32'(event_cnt), 32'h6);

      // 6: reset during HOLD
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      chk_eq("t6_vld",  32'(valid_out), 32'h0);
      chk_eq("t6_seen", 32'(seen_mask), 32'h0);
      step(0, 1, 3'd4, 0);
      chk_eq("t6_chg", 32'(changed), 32'h1);
      chk_eq("t6_dec", 32'(dec_out), 32'h10);

      // Random traffic with sparse clr/rst
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 59) == 0),
              ($urandom_range(0, 2) != 0),
              3'($urandom_range(0, 7)),
              ($urandom_range(0, 24) == 0));
      end
      // Long idle run so the hold window fully drains
      for (int i = 0; i < HOLD + 2; i++) step(0, 0, 0, 0);
      chk_eq("drain_vld", 32'(valid_out), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
